// File: rtl/ccff_stream_loader.sv
// Loads a ccff configuration chain from a word-wide bitstream (LSB first) and
// folds every bit leaving the chain tail into a readback parity bit.
module ccff_stream_loader #(
    parameter int CHAIN_LEN = 24,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    input  logic              ccff_tail,
    output logic              ccff_head,
    output logic              config_enable,
    output logic              busy,
    output logic              done,
    output logic              tail_parity
);
    localparam int REM_W = $clog2(CHAIN_LEN + 1);
    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [REM_W-1:0] REM_FULL = REM_W'(CHAIN_LEN);
    localparam logic [REM_W-1:0] REM_LAST = REM_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    logic [REM_W-1:0]  remaining_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [WORD_W-1:0] shreg_r;
    logic              bs_ready_r;
    logic              ccff_head_r;
    logic              config_enable_r;
    logic              busy_r;
    logic              done_r;
    logic              tail_parity_r;

    function automatic logic parity_fold(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

    // Control FSM and datapath; every output is a flop set for the state being entered
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_r         <= IDLE;
            remaining_r     <= '0;
            bit_cnt_r       <= '0;
            shreg_r         <= '0;
            bs_ready_r      <= 1'b0;
            ccff_head_r     <= 1'b0;
            config_enable_r <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            tail_parity_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r       <= LOAD;
                        remaining_r   <= REM_FULL;
                        tail_parity_r <= 1'b0;
                        busy_r        <= 1'b1;
                        bs_ready_r    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    if (bs_valid) begin
                        state_r         <= SHIFT;
                        shreg_r         <= bs_data;
                        bit_cnt_r       <= '0;
                        bs_ready_r      <= 1'b0;
                        config_enable_r <= 1'b1;
                        ccff_head_r     <= bs_data[0];
                    end else begin
                        state_r <= LOAD;
                    end
                end
                SHIFT: begin
                    shreg_r       <= shreg_r >> 1;
                    bit_cnt_r     <= bit_cnt_r + CNT_ONE;
                    remaining_r   <= remaining_r - REM_LAST;
                    tail_parity_r <= parity_fold(tail_parity_r, ccff_tail);
                    // Chain length wins over word length so surplus word bits never reach the head
                    if (remaining_r == REM_LAST) begin
                        state_r         <= DONE;
                        config_enable_r <= 1'b0;
                        ccff_head_r     <= 1'b0;
                        done_r          <= 1'b1;
                    end else if (bit_cnt_r == CNT_LAST) begin
                        state_r         <= LOAD;
                        config_enable_r <= 1'b0;
                        ccff_head_r     <= 1'b0;
                        bs_ready_r      <= 1'b1;
                    end else begin
                        state_r     <= SHIFT;
                        ccff_head_r <= shreg_r[1];
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r         <= IDLE;
                    bs_ready_r      <= 1'b0;
                    ccff_head_r     <= 1'b0;
                    config_enable_r <= 1'b0;
                    busy_r          <= 1'b0;
                    done_r          <= 1'b0;
                end
            endcase
        end
    end

    assign bs_ready      = bs_ready_r;
    assign ccff_head     = ccff_head_r;
    assign config_enable = config_enable_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign tail_parity   = tail_parity_r;

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Scoreboard bench: two loaders (24-bit and 20-bit chains) driven one at a time
// against a bench-side chain model and word-to-bitstream reference.
`timescale 1ns/1ps
module tb_ccff_stream_loader;
    localparam int W     = 8;
    localparam int CL0   = 24;
    localparam int CL1   = 20;
    localparam int CLMAX = 24;
    localparam int MAXW  = 3;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic         pReset        [2];
    logic         start         [2];
    logic [W-1:0] bs_data       [2];
    logic         bs_valid      [2];
    logic         bs_ready      [2];
    logic         ccff_tail     [2];
    logic         ccff_head     [2];
    logic         config_enable [2];
    logic         busy          [2];
    logic         done          [2];
    logic         tail_parity   [2];

    logic [CLMAX-1:0] chain       [2];
    logic [CLMAX-1:0] preload_val [2];
    logic             preload_req [2];
    logic             mon_on;
    logic [W-1:0]     words [MAXW];

    bit exp_head_q [$];
    bit exp_par_q  [$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int en_cnt   [2];
    int done_cnt [2];

    ccff_stream_loader #(.CHAIN_LEN(CL0), .WORD_W(W)) dut0 (
        .prog_clk(prog_clk), .pReset(pReset[0]), .start(start[0]),
        .bs_data(bs_data[0]), .bs_valid(bs_valid[0]), .bs_ready(bs_ready[0]),
        .ccff_tail(ccff_tail[0]), .ccff_head(ccff_head[0]),
        .config_enable(config_enable[0]), .busy(busy[0]), .done(done[0]),
        .tail_parity(tail_parity[0])
    );

    ccff_stream_loader #(.CHAIN_LEN(CL1), .WORD_W(W)) dut1 (
        .prog_clk(prog_clk), .pReset(pReset[1]), .start(start[1]),
        .bs_data(bs_data[1]), .bs_valid(bs_valid[1]), .bs_ready(bs_ready[1]),
        .ccff_tail(ccff_tail[1]), .ccff_head(ccff_head[1]),
        .config_enable(config_enable[1]), .busy(busy[1]), .done(done[1]),
        .tail_parity(tail_parity[1])
    );

    function automatic void check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    function automatic void check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    always @(posedge prog_clk) cyc <= cyc + 1;

    // Downstream chain model: shifts head in when enabled, tail is its last element
    always @(posedge prog_clk) begin
        for (int d = 0; d < 2; d++) begin
            if (preload_req[d]) chain[d] <= preload_val[d];
            else if (config_enable[d]) chain[d] <= {chain[d][CLMAX-2:0], ccff_head[d]};
        end
    end
    assign ccff_tail[0] = chain[0][CL0-1];
    assign ccff_tail[1] = chain[1][CL1-1];

    // Monitor: pops the scoreboard whenever a DUT shifts a bit or pulses done
    always @(negedge prog_clk) begin
        if (mon_on) begin
            for (int d = 0; d < 2; d++) begin
                if (config_enable[d]) begin
                    en_cnt[d] <= en_cnt[d] + 1;
                    check_bit("shift_ready_low", bs_ready[d], 1'b0);
                    check_bit("shift_busy", busy[d], 1'b1);
                    check_int("head_bits_pending", int'(exp_head_q.size() > 0), 1);
                    if (exp_head_q.size() > 0) check_bit("ccff_head", ccff_head[d], exp_head_q.pop_front());
                end else begin
                    check_bit("head_idle_zero", ccff_head[d], 1'b0);
                end
                if (done[d]) begin
                    done_cnt[d] <= done_cnt[d] + 1;
                    check_int("parity_pending", int'(exp_par_q.size() > 0), 1);
                    if (exp_par_q.size() > 0) check_bit("tail_parity_done", tail_parity[d], exp_par_q.pop_front());
                end
            end
        end
    end

    task automatic run_load(input int d, input int stall_idx, input int stall_len,
                            input bit glitch, input bit abort, input logic [CLMAX-1:0] pre);
        int L, nw, nbits, c_start, en0, done0, waitc, stall_cnt;
        logic par;
        logic [CLMAX-1:0] img, mask;
        L  = (d == 0) ? CL0 : CL1;
        nw = (L + W - 1) / W;
        preload_val[d] = pre;
        preload_req[d] = 1'b1;
        @(negedge prog_clk);
        preload_req[d] = 1'b0;
        nbits = abort ? (W + 3) : L;
        par = 1'b0;
        img = '0;
        mask = '0;
        for (int k = 0; k < nbits; k++) exp_head_q.push_back(words[k / W][k % W]);
        for (int k = 0; k < L; k++) begin
            par = par ^ pre[k];
            img[L-1-k] = words[k / W][k % W];
            mask[k] = 1'b1;
        end
        if (!abort) exp_par_q.push_back(par);
        stall_cnt = (stall_idx >= 0) ? stall_len : 0;
        en0 = en_cnt[d];
        done0 = done_cnt[d];
        start[d] = 1'b1;
        c_start = cyc;
        @(negedge prog_clk);
        start[d] = 1'b0;
        for (int i = 0; i < nw; i++) begin
            waitc = 0;
            while (!bs_ready[d] && waitc < 50) begin
                @(negedge prog_clk);
                waitc++;
            end
            check_bit("ready_wait", bs_ready[d], 1'b1);
            if (i == stall_idx) begin
                for (int s = 0; s < stall_len; s++) begin
                    check_bit("stall_ready", bs_ready[d], 1'b1);
                    check_bit("stall_enable", config_enable[d], 1'b0);
                    @(negedge prog_clk);
                end
            end
            bs_data[d] = words[i];
            bs_valid[d] = 1'b1;
            @(negedge prog_clk);
            bs_valid[d] = 1'b0;
            bs_data[d] = W'($urandom);
            if (glitch && i == 0) begin
                start[d] = 1'b1;
                @(negedge prog_clk);
                start[d] = 1'b0;
            end
            if (abort && i == 1) begin
                // now in enabled cycle 1 of word 2; assert reset during cycle 3
                @(negedge prog_clk);
                @(negedge prog_clk);
                pReset[d] = 1'b1;
                @(negedge prog_clk);
                pReset[d] = 1'b0;
                check_bit("abort_busy", busy[d], 1'b0);
                check_bit("abort_enable", config_enable[d], 1'b0);
                check_bit("abort_head", ccff_head[d], 1'b0);
                check_bit("abort_ready", bs_ready[d], 1'b0);
                check_bit("abort_parity", tail_parity[d], 1'b0);
                check_int("abort_bits_left", exp_head_q.size(), 0);
                repeat (4) @(negedge prog_clk);
                check_int("abort_no_done", done_cnt[d] - done0, 0);
                check_int("abort_en_count", en_cnt[d] - en0, W + 3);
                return;
            end
        end
        waitc = 0;
        while (!done[d] && waitc < 100) begin
            @(negedge prog_clk);
            waitc++;
        end
        check_bit("done_seen", done[d], 1'b1);
        check_int("latency", cyc - c_start + 1, 2 + nw + L + stall_cnt);
        @(negedge prog_clk);
        check_bit("done_one_cycle", done[d], 1'b0);
        check_bit("busy_after", busy[d], 1'b0);
        check_int("enabled_cycles", en_cnt[d] - en0, L);
        check_int("done_pulses", done_cnt[d] - done0, 1);
        check_int("chain_image", int'(chain[d] & mask), int'(img));
        repeat (3) @(negedge prog_clk);
        check_bit("parity_hold", tail_parity[d], par);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mon_on = 1'b0;
        for (int d = 0; d < 2; d++) begin
            pReset[d] = 1'b1;
            start[d] = 1'b0;
            bs_data[d] = '0;
            bs_valid[d] = 1'b0;
            preload_req[d] = 1'b0;
            preload_val[d] = '0;
        end
        repeat (3) @(negedge prog_clk);
        for (int d = 0; d < 2; d++) begin
            check_bit("rst_bs_ready", bs_ready[d], 1'b0);
            check_bit("rst_ccff_head", ccff_head[d], 1'b0);
            check_bit("rst_config_enable", config_enable[d], 1'b0);
            check_bit("rst_busy", busy[d], 1'b0);
            check_bit("rst_done", done[d], 1'b0);
            check_bit("rst_tail_parity", tail_parity[d], 1'b0);
            pReset[d] = 1'b0;
        end
        mon_on = 1'b1;

        // start together with reset must be ignored
        pReset[0] = 1'b1;
        start[0] = 1'b1;
        @(negedge prog_clk);
        pReset[0] = 1'b0;
        start[0] = 1'b0;
        check_bit("start_vs_reset_busy", busy[0], 1'b0);
        check_bit("start_vs_reset_ready", bs_ready[0], 1'b0);
        @(negedge prog_clk);
        check_bit("start_vs_reset_idle", busy[0], 1'b0);

        // full load, readback chain preloaded with seven ones
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF0;
        run_load(0, -1, 0, 1'b0, 1'b0, 24'h00_007F);
        // partial last word on the 20-bit chain
        words[0] = 8'hFF; words[1] = 8'hFF; words[2] = 8'hFF;
        run_load(1, -1, 0, 1'b0, 1'b0, 24'h0A_5A5A);
        // five-cycle stall before the second word, then start pulsed mid-load
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF0;
        run_load(0, 1, 5, 1'b0, 1'b0, 24'h12_3456);
        run_load(0, -1, 0, 1'b1, 1'b0, 24'hFF_FFFF);
        // reset mid-shift, then a clean full load
        run_load(0, -1, 0, 1'b0, 1'b1, 24'h00_0000);
        run_load(0, -1, 0, 1'b0, 1'b0, 24'h80_0001);

        for (int it = 0; it < 16; it++) begin
            int d, sidx, slen;
            d = it % 2;
            for (int i = 0; i < MAXW; i++) words[i] = W'($urandom);
            sidx = int'($urandom_range(0, 3)) - 1;
            slen = int'($urandom_range(1, 4));
            run_load(d, sidx, slen, 1'($urandom_range(0, 1)), 1'b0, CLMAX'($urandom));
        end

        check_int("head_queue_drained", exp_head_q.size(), 0);
        check_int("parity_queue_drained", exp_par_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ccff_stream_loader.md
CCFF_STREAM_LOADER -- requirements
Module: ccff_stream_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 24, giving the number of configuration bits in the downstream ccff chain (range 1..4095).
REQ-002 SHALL have parameter WORD_W, default 8, giving the bitstream word width (range 2..32).
REQ-003 SHALL have port prog_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port pReset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request to begin loading the chain.
REQ-006 SHALL have port bs_data, input, WORD_W bits: a bitstream word, sent LSB first.
REQ-007 SHALL have port bs_valid, input, 1 bit: bs_data is valid.
REQ-008 SHALL have port bs_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-009 SHALL have port ccff_tail, input, 1 bit: the serial output of the last chain element.
REQ-010 SHALL have port ccff_head, output, 1 bit: the serial data into the first chain element.
REQ-011 SHALL have port config_enable, output, 1 bit: the chain shift enable.
REQ-012 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-013 SHALL have port done, output, 1 bit: a one-cycle pulse when the load completes.
REQ-014 SHALL have port tail_parity, output, 1 bit: the XOR of all ccff_tail bits shifted out during the current or last load.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, SHIFT and DONE.
REQ-016 In IDLE, start=1 SHALL cause a transition to LOAD and load remaining_bits=CHAIN_LEN, tail_parity=0.
- start SHALL be ignored in every state other than IDLE.
REQ-017 bs_ready SHALL be 1 only in LOAD and SHALL be registered.
- A word SHALL be accepted on a cycle with bs_ready=1 and bs_valid=1.
- On acceptance the word SHALL be captured into the shift register, and the state SHALL go to SHIFT with bit_cnt=0.
REQ-018 In SHIFT, on each cycle:
- config_enable=1 and ccff_head=shreg[0];
- on the clock edge, shreg shifts right by one, bit_cnt increments, remaining_bits decrements, and tail_parity ^= ccff_tail.
REQ-019 SHIFT SHALL end after the cycle in which bit_cnt=WORD_W-1 or remaining_bits=1, whichever comes first.
- If remaining_bits reaches 0 the next state is DONE; otherwise it is LOAD.
REQ-020 Excess bits of the final partial word SHALL be discarded and never driven on ccff_head.
REQ-021 Timing of config_enable:
- config_enable SHALL be 0 in IDLE, LOAD and DONE, so exactly CHAIN_LEN enabled cycles occur per load.
- The first enabled cycle SHALL be the cycle immediately after the first word is accepted.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE.
- busy SHALL be 1 in LOAD, SHIFT and DONE, and 0 in IDLE.
REQ-023 bs_valid=0 while in LOAD SHALL stall with config_enable=0.
- No chain bit is lost and no timeout applies.
REQ-024 ccff_head SHALL be 0 whenever config_enable=0.
REQ-025 tail_parity SHALL hold its value from DONE until the next accepted start.
REQ-026 All outputs SHALL be driven from flops, with no combinational path from input to output.

Reset
REQ-027 While pReset=1 at a prog_clk edge, the state SHALL go to IDLE and all of the following SHALL be 0 on the next cycle:
- bs_ready, ccff_head, config_enable, busy, done, tail_parity;
- remaining_bits, bit_cnt, shreg.
REQ-028 pReset asserted during LOAD or SHIFT SHALL abort the load with no done pulse, and config_enable=0 from the next cycle.
REQ-029 pReset SHALL take priority over start in the same cycle.

Verification
REQ-030 Full load with CHAIN_LEN=24 and WORD_W=8: start, then words 0xA5, 0x3C, 0xF0, each presented with bs_valid=1 -> ccff_head over 24 enabled cycles = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 0,0,0,0,1,1,1,1; then done pulses once; total start-to-done latency = 1+3*(1+8)+1 cycles.
REQ-031 Partial last word with CHAIN_LEN=20 and WORD_W=8: words 0xFF, 0xFF, 0xFF -> exactly 20 enabled cycles; the third SHIFT lasts 4 cycles; ccff_head=0 after that; done asserts.
REQ-032 Stall: bs_valid held at 0 for 5 cycles before the second word -> config_enable=0 and bs_ready=1 throughout the gap; the bit sequence is unchanged versus the no-stall case.
REQ-033 Readback parity: chain model preloaded with 24 bits containing seven 1s -> tail_parity=1 after done and held until the next start.
REQ-034 Reset mid-SHIFT: pReset=1 on the 3rd enabled cycle of word 2 -> next cycle busy=0, config_enable=0, ccff_head=0, and no done pulse; a following start performs a full correct load.
REQ-035 start asserted while busy, and start together with pReset -> start ignored; the load count and ccff_head sequence are unaffected.
